pt_ring_egress_drain: RTL and testbench

Reader/transmitter end of the ring stop's two-entry register FIFOs. Drains the ring-through FIFO and the local-injection FIFO (both empty/rdEn/rdDat interface) and forwards flits onto the outgoing ring link under credit-based flow control. Packets are never interleaved. A starvation counter guarantees the local source progress against ring-priority traffic.

---
 rtl/pt_ring_pkg.sv | 31 +++
 rtl/pt_ring_egress_drain_if.sv | 31 +++
 rtl/pt_ring_credit_cnt.sv | 35 +++
 rtl/pt_ring_egress_drain.sv | 102 ++++++++++
 tb/tb_pt_ring_egress_drain.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pt_ring_pkg.sv
// Shared definitions for the ring stop: flit type field, its decoders, and the egress
// drain state encoding.
package pt_ring_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef logic [1:0] egress_state_t;
    localparam egress_state_t IDLE     = 2'd0;
    localparam egress_state_t RING_PKT = 2'd1;
    localparam egress_state_t LOC_PKT  = 2'd2;

    // Takes the two most significant bits of a flit.
    function automatic flit_type_e flit_type(input logic [1:0] type_field);
        return flit_type_e'(type_field);
    endfunction

    function automatic logic opens_pkt(input flit_type_e t);
        return t == FLIT_HEAD;
    endfunction

    // A single flit carries the tail marker too, so it also closes an open packet.
    function automatic logic closes_pkt(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/pt_ring_egress_drain_if.sv
// Egress drain bundle: the two upstream FIFO read ports, the outgoing ring link, and
// credit return/status. The master side is the drain itself.
interface pt_ring_egress_drain_if #(
    parameter int WIDTH   = 8,
    parameter int CREDITS = 2
);
    localparam int CW = $clog2(CREDITS + 1);

    logic             ring_empty;
    logic [WIDTH-1:0] ring_dat;
    logic             ring_rd_en;
    logic             loc_empty;
    logic [WIDTH-1:0] loc_dat;
    logic             loc_rd_en;
    logic             link_vld;
    logic [WIDTH-1:0] link_dat;
    logic             link_crd;
    logic [CW-1:0]    crd_cnt;
    logic             crd_err;

    modport master (
        input  ring_empty, ring_dat, loc_empty, loc_dat, link_crd,
        output ring_rd_en, loc_rd_en, link_vld, link_dat, crd_cnt, crd_err
    );

    modport slave (
        output ring_empty, ring_dat, loc_empty, loc_dat, link_crd,
        input  ring_rd_en, loc_rd_en, link_vld, link_dat, crd_cnt, crd_err
    );

endinterface

// File: rtl/pt_ring_credit_cnt.sv
// Saturating up/down credit counter for the outgoing link, with a sticky flag
// raised when the downstream returns more credits than it was given.
module pt_ring_credit_cnt #(
    parameter int CREDITS = 2,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          err
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= CW'(CREDITS);
            err <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (cnt == CW'(CREDITS)) err <= 1'b1;
                    else                     cnt <= cnt + CW'(1);
                end
                2'b01: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pt_ring_egress_drain.sv
// Ring stop egress: drains the ring-through and local FIFOs onto the outgoing link
// without interleaving packets, gated by link credits, with a starvation guard for local.
module pt_ring_egress_drain
    import pt_ring_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CREDITS    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                     clk,
    input logic                     rst,
    pt_ring_egress_drain_if.master  bus
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    egress_state_t    state, state_nxt;
    logic [SW-1:0]    starve;
    logic [CW-1:0]    crd_cnt;
    logic             crd_err;
    logic             crd_ok;
    logic             loc_forced;
    logic             pop_ring, pop_loc, pop;
    logic [WIDTH-1:0] pop_dat;
    flit_type_e       pop_type;

    // The gate sees the registered count, so a credit returned at zero only helps next cycle.
    assign crd_ok     = (crd_cnt != '0);
    assign loc_forced = (starve == SW'(STARVE_MAX)) && !bus.loc_empty;

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pop_ring = 1'b0;
        pop_loc  = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.ring_empty && !loc_forced) pop_ring = crd_ok;
                else if (!bus.loc_empty)            pop_loc  = crd_ok;
            end
            RING_PKT: pop_ring = !bus.ring_empty && crd_ok;
            LOC_PKT:  pop_loc  = !bus.loc_empty && crd_ok;
            default: ;
        endcase
    end

    assign pop      = pop_ring || pop_loc;
    assign pop_dat  = pop_loc ? bus.loc_dat : bus.ring_dat;
    assign pop_type = flit_type(pop_dat[WIDTH-1 -: 2]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pop && opens_pkt(pop_type)) state_nxt = pop_ring ? RING_PKT : LOC_PKT;
            end
            RING_PKT, LOC_PKT: begin
                if (pop && closes_pkt(pop_type)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            starve       <= '0;
            bus.link_vld <= 1'b0;
            bus.link_dat <= '0;
        end else begin
            state        <= state_nxt;
            bus.link_vld <= pop;
            if (pop) bus.link_dat <= pop_dat;
            // Starvation only counts ring grants that overtook a waiting local packet.
            if (state == IDLE) begin
                if (pop_loc)
                    starve <= '0;
                else if (pop_ring && !bus.loc_empty && starve != SW'(STARVE_MAX))
                    starve <= starve + SW'(1);
            end
        end
    end

    pt_ring_credit_cnt #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_credit_cnt (
        .clk (clk),
        .rst (rst),
        .dec (pop),
        .inc (bus.link_crd),
        .cnt (crd_cnt),
        .err (crd_err)
    );

    assign bus.ring_rd_en = pop_ring;
    assign bus.loc_rd_en  = pop_loc;
    assign bus.crd_cnt    = crd_cnt;
    assign bus.crd_err    = crd_err;

endmodule

// File: tb/tb_pt_ring_egress_drain.sv
// Directed bench for pt_ring_egress_drain: FWFT FIFO models feed the drain, expected
// link flits go to a scoreboard queue that an independent monitor consumes.
module tb_pt_ring_egress_drain;

    logic clk;
    logic rst;
    logic auto_crd;
    logic man_crd;

    int tests;
    int failed;

    logic [7:0] ring_q[$];
    logic [7:0] loc_q[$];
    logic [7:0] stg_ring[$];
    logic [7:0] stg_loc[$];
    logic [7:0] exp_q[$];

    pt_ring_egress_drain_if #(.WIDTH(8), .CREDITS(2)) bus ();

    pt_ring_egress_drain #(
        .WIDTH      (8),
        .CREDITS    (2),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream model: either echoes every delivered flit as a credit, or takes manual pulses.
    assign bus.link_crd = auto_crd ? bus.link_vld : man_crd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upstream FWFT FIFOs: pops land on the edge where rd_en is seen, staged pushes join after.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_q.delete();
            loc_q.delete();
        end else begin
            if (bus.ring_rd_en && ring_q.size() != 0) void'(ring_q.pop_front());
            if (bus.loc_rd_en && loc_q.size() != 0)   void'(loc_q.pop_front());
            while (stg_ring.size() != 0) ring_q.push_back(stg_ring.pop_front());
            while (stg_loc.size() != 0)  loc_q.push_back(stg_loc.pop_front());
        end
        bus.ring_empty <= (ring_q.size() == 0);
        bus.ring_dat   <= (ring_q.size() != 0) ? ring_q[0] : 8'h00;
        bus.loc_empty  <= (loc_q.size() == 0);
        bus.loc_dat    <= (loc_q.size() != 0) ? loc_q[0] : 8'h00;
    end

    // Monitor: scoreboard the link and police the read-enable rules.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.link_vld) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL link_unexpected: got %0h, expected no flit (t=%0t)", bus.link_dat, $time);
                end else begin
                    check("link_dat", bus.link_dat, exp_q.pop_front());
                end
            end
            if (bus.ring_rd_en || bus.loc_rd_en) begin
                check("rd_en_exclusive", bus.ring_rd_en && bus.loc_rd_en, 0);
                check("rd_en_on_empty", (bus.ring_rd_en && bus.ring_empty) ||
                                        (bus.loc_rd_en && bus.loc_empty), 0);
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        auto_crd = 1'b0;
        man_crd  = 1'b0;
        stg_ring.delete();
        stg_loc.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        failed   = 0;
        auto_crd = 1'b0;
        man_crd  = 1'b0;
        rst      = 1'b0;
        #1 rst   = 1'b1;

        // 1: reset, idle link
        do_reset();
        for (int i = 0; i < 10; i++) begin
            check("idle_outputs", {bus.link_vld, bus.ring_rd_en, bus.loc_rd_en}, 0);
            check("idle_crd_cnt", bus.crd_cnt, 2);
            @(negedge clk);
        end
        check("idle_crd_err", bus.crd_err, 0);

        // 2: single ring flit, one credit consumed and returned
        stg_ring.push_back(8'hC5);
        exp_q.push_back(8'hC5);
        @(negedge clk);
        check("single_rd_en", bus.ring_rd_en, 1);
        @(negedge clk);
        check("single_crd_after_pop", bus.crd_cnt, 1);
        man_crd = 1'b1;
        @(negedge clk);
        man_crd = 1'b0;
        check("single_crd_returned", bus.crd_cnt, 2);
        wait_drain("single_drain", 10);

        // 3: ring packet is not interleaved by a waiting local single
        do_reset();
        auto_crd = 1'b1;
        stg_ring.push_back(8'h41);
        stg_ring.push_back(8'h02);
        stg_ring.push_back(8'h83);
        stg_loc.push_back(8'hC9);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h83);
        exp_q.push_back(8'hC9);
        wait_drain("pkt_drain", 30);

        // 4: credits withheld, then released one at a time
        do_reset();
        stg_ring.push_back(8'hC1);
        stg_ring.push_back(8'hC2);
        stg_ring.push_back(8'hC3);
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC3);
        repeat (6) @(negedge clk);
        check("nocrd_cnt_zero", bus.crd_cnt, 0);
        check("nocrd_stall", bus.ring_rd_en, 0);
        check("nocrd_pending", exp_q.size(), 1);
        man_crd = 1'b1;
        #1 check("nocrd_same_cycle_gate", bus.ring_rd_en, 0);
        @(negedge clk);
        man_crd = 1'b0;
        check("nocrd_resume_rd_en", bus.ring_rd_en, 1);
        check("nocrd_resume_cnt", bus.crd_cnt, 1);
        wait_drain("nocrd_drain", 10);

        // 5: starvation guard, local every fifth grant
        do_reset();
        auto_crd = 1'b1;
        for (int i = 0; i < 10; i++) stg_ring.push_back(8'hC0 + 8'(i));
        for (int i = 0; i < 3; i++)  stg_loc.push_back(8'hF0 + 8'(i));
        exp_q.push_back(8'hC0); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC3); exp_q.push_back(8'hF0);
        exp_q.push_back(8'hC4); exp_q.push_back(8'hC5); exp_q.push_back(8'hC6);
        exp_q.push_back(8'hC7); exp_q.push_back(8'hF1);
        exp_q.push_back(8'hC8); exp_q.push_back(8'hC9); exp_q.push_back(8'hF2);
        wait_drain("starve_drain", 40);
        check("starve_crd_steady", bus.crd_cnt, 2);

        // 6a: credit overflow is sticky
        do_reset();
        man_crd = 1'b1;
        @(negedge clk);
        man_crd = 1'b0;
        check("ovf_cnt_sat", bus.crd_cnt, 2);
        check("ovf_err_set", bus.crd_err, 1);
        repeat (3) @(negedge clk);
        check("ovf_err_sticky", bus.crd_err, 1);

        // 6b: reset while a ring packet streams, then a local single must still get through
        auto_crd = 1'b1;
        stg_ring.push_back(8'h41);
        for (int i = 0; i < 5; i++) stg_ring.push_back(8'h02);
        exp_q.push_back(8'h41);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h02);
        repeat (3) @(posedge clk);
        #3 check("midpkt_streaming", bus.link_vld, 1);
        rst = 1'b1;
        stg_ring.delete();
        exp_q.delete();
        #1;
        check("rst_link_vld", bus.link_vld, 0);
        check("rst_link_dat", bus.link_dat, 0);
        check("rst_crd_cnt", bus.crd_cnt, 2);
        check("rst_crd_err", bus.crd_err, 0);
        check("rst_rd_en", {bus.ring_rd_en, bus.loc_rd_en}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stg_loc.push_back(8'hCA);
        exp_q.push_back(8'hCA);
        wait_drain("post_rst_drain", 20);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
